// File: rtl/uart_pkg.sv
// uart_pkg: UART state type and default timing constants shared by uart_rx and uart_tx
package uart_pkg;
   localparam int DEF_CLOCK_FREQ = 50_000_000;
   localparam int DEF_BAUD_RATE  = 115_200;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_state_t;
   function automatic int bit_clks(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate + 1;
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous rx line, resets to idle-high
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);
   logic r_meta;
   // back-to-back flops; reset to 1 so leaving reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         o_sync <= 1'b1;
      end else begin
         r_meta <= i_async;
         o_sync <= r_meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with holding register; UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int DATA_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int BIT_CLKS = bit_clks(CLOCK_FREQ, BAUD_RATE);
   localparam int CW = BIT_CLKS > 1 ? $clog2(BIT_CLKS) : 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   logic w_rx;
   logic w_prev;
   logic w_sample;
   uart_rx_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (rx),
      .o_sync  (w_rx)
   );
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
   logic [1:0] r_hist;
   // rx at mid-point-1 and mid-point, voted with the current value at mid-point+1
   always_ff @(posedge clk) r_hist <= rst ? 2'b11 : {r_hist[0], w_rx};
   assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
   assign w_prev = r_hist[0];
`else
   localparam int MAJ = 0;
   logic r_prev;
   // previous synchronized rx for falling-edge detection
   always_ff @(posedge clk) r_prev <= rst ? 1'b1 : w_rx;
   assign w_sample = w_rx;
   assign w_prev = r_prev;
`endif
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1 + MAJ);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   uart_state_t          r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_tick;
   assign w_tick = r_cnt == (r_state == START ? HALF_LAST : BIT_LAST);
   // frame FSM, bit timing and holding-register handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (data_valid && data_ready) data_valid <= 1'b0;
         r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
         case (r_state)
            IDLE: if (w_prev && !w_rx) r_state <= START;
            START: if (w_tick) begin
               r_bit   <= '0;
               r_state <= w_sample ? IDLE : DATA;
            end
            DATA: if (w_tick) begin
               r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
               r_bit   <= r_bit + 1'b1;
               if (r_bit == DATA_LAST) r_state <= STOP;
            end
            STOP: if (w_tick) begin
               if (w_sample && (!data_valid || data_ready)) begin
                  data       <= r_shift;
                  data_valid <= 1'b1;
               end
               overrun   <= w_sample && data_valid && !data_ready;
               frame_err <= !w_sample;
               r_state   <= w_sample ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: if (w_rx) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked against a frame-level reference of the receiver
module tb_uart_rx;
   localparam int CF = 1000;
   localparam int BR = 100;
   localparam int DW = 16;
   localparam int BIT_CLKS = CF / BR + 1;
   localparam int HALF = BIT_CLKS / 2;
   localparam int FULL = 1 << 30;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
   localparam logic [DW-1:0] GLITCH_EXP = 16'h5555;
`else
   localparam int MAJ = 0;
   localparam logic [DW-1:0] GLITCH_EXP = 16'hAAAA;
`endif
   // start seen after 2 sync flops, mid-point after HALF, then DATA_BITS+1 bit periods to the stop sample
   localparam int LAT = 2 + HALF + (DW + 1) * BIT_CLKS + MAJ;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx = 1'b1;
   logic data_ready = 1'b1;
   logic [DW-1:0] data;
   logic data_valid;
   logic frame_err;
   logic overrun;
   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int rises;
   int ferrs;
   int ovrs;
   int rise_cyc;
   logic [DW-1:0] cap;
   logic prev_dv = 1'b0;
   uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      if (data_valid && !prev_dv) begin
         rises++;
         rise_cyc = cyc;
         cap = data;
      end
      if (frame_err) ferrs++;
      if (overrun) ovrs++;
      prev_dv = data_valid;
   endtask
   task automatic clear_mon();
      rises = 0;
      ferrs = 0;
      ovrs = 0;
      rise_cyc = -1;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         tick();
         rx = 1'b1;
      end
   endtask
   task automatic send(input logic [DW-1:0] w, input logic stop_b, input logic glitch, input int limit, output int t0);
      logic [DW+1:0] f;
      int k;
      f = {stop_b, w, 1'b0};
      k = 0;
      t0 = -1;
      for (int b = 0; b < DW + 2; b++)
         for (int j = 0; j < BIT_CLKS; j++) begin
            if (k == limit) return;
            tick();
            rx = f[b] ^ (glitch && b > 0 && b <= DW && j == HALF);
            if (k == 0) t0 = cyc + 1;
            k++;
         end
   endtask
   task automatic expect_frame(input string tag, input logic [DW-1:0] w, input int t0);
      idle(8);
      check({tag, "_count"}, rises, 1);
      check({tag, "_data"}, cap, w);
      check({tag, "_lat"}, rise_cyc, t0 + LAT);
      check({tag, "_ferr"}, ferrs, 0);
      check({tag, "_ovr"}, ovrs, 0);
   endtask
   task automatic check_cleared(input string tag);
      check({tag, "_data"}, data, 0);
      check({tag, "_dv"}, data_valid, 0);
      check({tag, "_ferr"}, frame_err, 0);
      check({tag, "_ovr"}, overrun, 0);
   endtask
   initial begin
      int t0;
      logic [DW-1:0] w;
      clear_mon();
      idle(3);
      check_cleared("reset");
      rst = 1'b0;
      idle(20);
      clear_mon();
      send(16'hA5C3, 1'b1, 1'b0, FULL, t0);
      expect_frame("a5c3", 16'hA5C3, t0);
      repeat (6) begin
         w = DW'($urandom);
         idle($urandom_range(1, 30));
         clear_mon();
         send(w, 1'b1, 1'b0, FULL, t0);
         expect_frame("rand", w, t0);
      end
      clear_mon();
      repeat (3) begin
         tick();
         rx = 1'b0;
      end
      idle(40);
      check("false_start_dv", rises, 0);
      check("false_start_ferr", ferrs, 0);
      clear_mon();
      send(16'h1234, 1'b0, 1'b0, FULL, t0);
      repeat (50) begin
         tick();
         rx = 1'b0;
      end
      check("break_ferr_pulses", ferrs, 1);
      check("break_rises", rises, 0);
      check("break_dv", data_valid, 0);
      idle(2 * BIT_CLKS);
      clear_mon();
      send(16'h0001, 1'b1, 1'b0, FULL, t0);
      expect_frame("after_break", 16'h0001, t0);
      data_ready = 1'b0;
      clear_mon();
      send(16'h00FF, 1'b1, 1'b0, FULL, t0);
      idle(5);
      send(16'hFF00, 1'b1, 1'b0, FULL, t0);
      idle(8);
      check("ovr_pulses", ovrs, 1);
      check("ovr_rises", rises, 1);
      check("ovr_data", data, 16'h00FF);
      check("ovr_dv", data_valid, 1);
      tick();
      data_ready = 1'b1;
      tick();
      tick();
      check("ovr_clear", data_valid, 0);
      idle(10);
      clear_mon();
      send(16'hBEEF, 1'b1, 1'b0, 8 * BIT_CLKS + HALF, t0);
      rst = 1'b1;
      rx = 1'b1;
      idle(2);
      check_cleared("midreset");
      rst = 1'b0;
      idle(3 * BIT_CLKS);
      check("midreset_quiet", rises + ferrs + ovrs, 0);
      clear_mon();
      send(16'h0F0F, 1'b1, 1'b0, FULL, t0);
      expect_frame("after_reset", 16'h0F0F, t0);
      idle(10);
      clear_mon();
      send(16'h5555, 1'b1, 1'b1, FULL, t0);
      expect_frame("glitch", GLITCH_EXP, t0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
